// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single data-memory port: pipeline memory stage (A, default
// priority) and loader/debug port (B) with starvation guard, bounded lock bursts and 1-cycle read return.
module data_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [1:0]    a_size,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic [1:0]    b_size,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_writedata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [1:0]    mem_size,
    input  logic [DW-1:0] mem_readdata
);

    localparam int SW      = $clog2(STARVE_LIMIT + 1);
    localparam int LW      = $clog2(MAX_LOCK + 1);
    localparam bit LOCK_EN = (MAX_LOCK > 1);

    typedef enum logic {
        ARB,
        B_LOCKED
    } state_t;

    state_t        state_reg;
    logic [SW-1:0] starve_cnt_reg;
    logic [LW-1:0] lock_cnt_reg;
    logic [LW-1:0] lock_cnt_next;
    logic          pending_reg;
    logic          owner_reg;

    logic [1:0]          port_rvalid;
    logic [1:0][DW-1:0]  port_rdata;

    assign lock_cnt_next = lock_cnt_reg + LW'(1);

    // Grants are combinational so the memory stage sees its stall in the request cycle.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (state_reg == B_LOCKED) begin
                b_gnt = b_req;
            end else if (a_req && b_req) begin
                if (starve_cnt_reg == SW'(STARVE_LIMIT)) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    assign mem_addr      = b_gnt ? b_addr  : a_addr;
    assign mem_writedata = b_gnt ? b_wdata : a_wdata;
    assign mem_size      = b_gnt ? b_size  : a_size;
    assign mem_we        = (a_gnt & a_we)  | (b_gnt & b_we);
    assign mem_re        = (a_gnt & ~a_we) | (b_gnt & ~b_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB;
            starve_cnt_reg <= '0;
            lock_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            owner_reg      <= 1'b0;
        end else begin
            pending_reg <= mem_re;
            owner_reg   <= b_gnt;

            if (!b_req || b_gnt) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != SW'(STARVE_LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + SW'(1);
            end

            case (state_reg)
                ARB: begin
                    if (b_gnt && b_lock && LOCK_EN) begin
                        state_reg    <= B_LOCKED;
                        lock_cnt_reg <= LW'(1);
                    end
                end
                B_LOCKED: begin
                    if (!b_req) begin
                        state_reg <= ARB;
                    end else begin
                        lock_cnt_reg <= lock_cnt_next;
                        // A final beat is still granted when the lock drops or the burst cap is hit.
                        if (!b_lock || lock_cnt_next == LW'(MAX_LOCK)) begin
                            state_reg <= ARB;
                        end
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    // Per-port read return: owner sees memory data directly, others hold their last delivery.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic [DW-1:0] rdata_hold_reg;

        assign port_rvalid[gi] = pending_reg && (owner_reg == 1'(gi)) && !reset;
        assign port_rdata[gi]  = port_rvalid[gi] ? mem_readdata : rdata_hold_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_hold_reg <= '0;
            end else if (port_rvalid[gi]) begin
                rdata_hold_reg <= mem_readdata;
            end
        end
    end

    assign a_rvalid = port_rvalid[0];
    assign b_rvalid = port_rvalid[1];
    assign a_rdata  = port_rdata[0];
    assign b_rdata  = port_rdata[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios plus random two-port traffic
// against a rule-level arbitration model and a reference memory image.
module tb_data_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_LOCK     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [1:0]  a_size, b_size;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_writedata, mem_readdata;
    logic        mem_we, mem_re;
    logic [1:0]  mem_size;

    data_mem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_size(b_size),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_addr(mem_addr), .mem_writedata(mem_writedata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_size(mem_size), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          lock;
    } op_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    op_t   a_q[$];
    op_t   b_q[$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 0;
    bit    rst_drv;
    int    denials;
    bit    locked;
    int    beats;
    string glog;
    logic [31:0] last_data [2];
    logic [31:0] ref_mem   [0:1023];
    logic [31:0] store     [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in data memory with registered read.
    always @(posedge clk) begin
        if (mem_we) store[mem_addr[11:2]] <= mem_writedata;
        if (mem_re) mem_readdata <= store[mem_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%s expected=%s", name, act, exp);
        end
    endtask

    // Monitor: every cycle, compare read-return outputs against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev_a, ev_b;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rvalid_lost port=%0d due=%0d", sb[0].port, sb[0].due);
                void'(sb.pop_front());
            end
            ev_a = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == 1'b0);
            ev_b = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == 1'b1);
            chk("a_rvalid", a_rvalid, ev_a);
            chk("b_rvalid", b_rvalid, ev_b);
            if (ev_a || ev_b) begin
                last_data[ev_b] = sb[0].data;
                $display("read return cyc=%0d port=%s data=%h", cyc, ev_b ? "B" : "A", sb[0].data);
                void'(sb.pop_front());
            end
            chk("a_rdata", a_rdata, last_data[0]);
            chk("b_rdata", b_rdata, last_data[1]);
        end
    end

    task automatic drive();
        reset = rst_drv;
        a_req = (a_q.size() > 0);
        b_req = (b_q.size() > 0);
        if (a_req) begin
            a_we = a_q[0].we; a_addr = a_q[0].addr; a_wdata = a_q[0].wdata; a_size = a_q[0].size;
        end
        if (b_req) begin
            b_we = b_q[0].we; b_addr = b_q[0].addr; b_wdata = b_q[0].wdata; b_size = b_q[0].size;
        end
        b_lock = b_req ? b_q[0].lock : 1'b0;
    endtask

    // One clock cycle: drive, predict grants from the arbitration rules, check, update the model.
    task automatic step();
        bit  ea, eb;
        op_t op;
        drive();
        if (rst_drv) sb.delete();
        @(negedge clk);
        ea = 0;
        eb = 0;
        if (!rst_drv) begin
            if (locked) eb = b_req;
            else if (a_req && b_req) begin
                if (denials == STARVE_LIMIT) eb = 1; else ea = 1;
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        if (ea || eb) begin
            op = ea ? a_q[0] : b_q[0];
            chk("mem_we", mem_we, op.we);
            chk("mem_re", mem_re, !op.we);
            chk("mem_addr", mem_addr, op.addr);
            chk("mem_size", mem_size, op.size);
            if (op.we) begin
                chk("mem_writedata", mem_writedata, op.wdata);
                ref_mem[op.addr[11:2]] = op.wdata;
            end else begin
                sb.push_back('{eb, ref_mem[op.addr[11:2]], cyc + 1});
            end
            $display("grant cyc=%0d port=%s %s addr=%h", cyc, ea ? "A" : "B", op.we ? "WR" : "RD", op.addr);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
            chk("mem_re_idle", mem_re, 1'b0);
            if (!rst_drv) chk("mem_addr_idle", mem_addr, a_addr);
        end
        glog = {glog, ea ? "A" : (eb ? "B" : "-")};
        if (rst_drv) begin
            denials = 0;
            locked  = 0;
        end else if (eb) begin
            denials = 0;
            if (locked) begin
                beats++;
                if (!b_lock || beats == MAX_LOCK) locked = 0;
            end else if (b_lock && MAX_LOCK > 1) begin
                locked = 1;
                beats  = 1;
            end
        end else if (b_req) begin
            if (denials < STARVE_LIMIT) denials++;
        end else begin
            denials = 0;
            locked  = 0;
        end
        if (ea) void'(a_q.pop_front());
        if (eb) void'(b_q.pop_front());
        @(posedge clk);
        #1;
        if (rst_drv) begin
            last_data[0] = '0;
            last_data[1] = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((a_q.size() > 0 || b_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout got=%0d cycles expected=<200", n);
            a_q.delete();
            b_q.delete();
        end
        step();
        step();
    endtask

    function automatic op_t rand_op(input bit lock_ok);
        op_t o;
        o.we    = $urandom_range(0, 1);
        o.addr  = 32'h300 + ($urandom_range(0, 15) << 2);
        o.wdata = $urandom;
        o.size  = 2'($urandom_range(0, 3));
        o.lock  = lock_ok && ($urandom_range(0, 2) == 0);
        return o;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            store[i]   = '0;
        end
        a_we = 0; a_addr = '0; a_wdata = '0; a_size = '0;
        b_we = 0; b_addr = '0; b_wdata = '0; b_size = '0;
        last_data[0] = '0;
        last_data[1] = '0;
        denials = 0; locked = 0; beats = 0;

        // Reset with an A request pending: no grant may leak.
        a_q.push_back('{1'b0, 32'h100, 32'h0, 2'b10, 1'b0});
        rst_drv = 1;
        step();
        step();
        rst_drv = 0;
        mon_en  = 1;
        chk("reset_a_rdata", a_rdata, 32'h0);
        chk("reset_b_rdata", b_rdata, 32'h0);
        drain();

        // A-only write then read-back.
        a_q.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0});
        a_q.push_back('{1'b0, 32'h100, 32'h0,        2'b10, 1'b0});
        drain();
        chk("a_only_rdata", a_rdata, 32'hDEADBEEF);

        // Contention: B wins every STARVE_LIMIT+1-th cycle.
        for (int i = 0; i < 9; i++) a_q.push_back('{1'b0, 32'h400 + 4 * i, 32'h0, 2'b00, 1'b0});
        for (int i = 0; i < 2; i++) b_q.push_back('{1'b0, 32'h500 + 4 * i, 32'h0, 2'b00, 1'b0});
        glog = "";
        repeat (10) step();
        chk_str("contention_pattern", glog, "AAAABAAAAB");
        drain();

        // Lock burst capped at MAX_LOCK beats, then A even though b_lock stays high.
        for (int i = 0; i < 9; i++) b_q.push_back('{1'b0, 32'h600 + 4 * i, 32'h0, 2'b01, 1'b1});
        glog = "";
        step();
        for (int i = 0; i < 3; i++) a_q.push_back('{1'b0, 32'h700 + 4 * i, 32'h0, 2'b10, 1'b0});
        repeat (8) step();
        chk_str("lock_burst_pattern", glog, "BBBBBBBBA");
        drain();

        // Early lock release: 4th B beat is final, then A priority with cleared starvation.
        b_q.push_back('{1'b0, 32'h800, 32'h0, 2'b10, 1'b1});
        b_q.push_back('{1'b0, 32'h804, 32'h0, 2'b10, 1'b1});
        b_q.push_back('{1'b0, 32'h808, 32'h0, 2'b10, 1'b1});
        b_q.push_back('{1'b0, 32'h80C, 32'h0, 2'b10, 1'b0});
        b_q.push_back('{1'b0, 32'h810, 32'h0, 2'b10, 1'b0});
        glog = "";
        step();
        for (int i = 0; i < 3; i++) a_q.push_back('{1'b0, 32'h900 + 4 * i, 32'h0, 2'b10, 1'b0});
        repeat (5) step();
        chk_str("early_release_pattern", glog, "BBBBAA");
        drain();

        // Interleaved reads from alternating ports.
        a_q.push_back('{1'b1, 32'h200, 32'h11111111, 2'b10, 1'b0});
        b_q.push_back('{1'b1, 32'h204, 32'h22222222, 2'b10, 1'b0});
        drain();
        a_q.push_back('{1'b0, 32'h200, 32'h0, 2'b10, 1'b0});
        step();
        b_q.push_back('{1'b0, 32'h204, 32'h0, 2'b10, 1'b0});
        step();
        step();
        step();
        chk("interleave_a_rdata", a_rdata, 32'h11111111);
        chk("interleave_b_rdata", b_rdata, 32'h22222222);

        // Reset the cycle after a B read grant: its rvalid must never appear.
        b_q.push_back('{1'b0, 32'h100, 32'h0, 2'b10, 1'b0});
        step();
        a_q.push_back('{1'b0, 32'h204, 32'h0, 2'b10, 1'b0});
        rst_drv = 1;
        step();
        rst_drv = 0;
        chk("midreset_b_rdata", b_rdata, 32'h0);
        step();
        drain();

        // Randomized two-port traffic with occasional locks and resets.
        for (int i = 0; i < 600; i++) begin
            if (a_q.size() == 0 && $urandom_range(0, 1) == 1) a_q.push_back(rand_op(1'b0));
            if (b_q.size() == 0 && $urandom_range(0, 2) != 0) b_q.push_back(rand_op(1'b1));
            rst_drv = ($urandom_range(0, 99) == 0);
            step();
            rst_drv = 0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates the single data-memory port between two requesters: the pipeline memory stage (port A, default priority) and the serial program loader/debug port (port B). Each cycle it grants at most one access, drives the data-memory address/data/enable/size lines, and returns read data one cycle later to the owning requester. Port B is protected from starvation by a denial counter, and can lock the port for short bursts. The block sits between the memory stage registers and `data_memory`. A low `a_gnt` while `a_req` is high is the memory-stage stall.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_LIMIT`, 4, number of consecutive B denials that forces a B win
- `MAX_LOCK`, 8, maximum consecutive B grants while locked

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `a_req` in 1: port A request; held until granted
- `a_we` in 1: A write (1) / read (0)
- `a_addr` in AW: A address
- `a_wdata` in DW: A write data
- `a_size` in 2: A access size, passed to memory unchanged
- `a_gnt` out 1: A granted this cycle
- `a_rdata` out DW: A read data
- `a_rvalid` out 1: A read data valid
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_size`: as for A, port B
- `b_lock` in 1: B requests to keep the port after its current grant
- `b_gnt`, `b_rdata`, `b_rvalid` out: as for A, port B
- `mem_addr` out AW: to data memory
- `mem_writedata` out DW: to data memory
- `mem_we` out 1: to data memory
- `mem_re` out 1: to data memory
- `mem_size` out 2: to data memory
- `mem_readdata` in DW: registered read data, valid the cycle after `mem_re`

## Operation
- **States:** `ARB` (normal arbitration) and `B_LOCKED`.
- **ARB, single request:** the only requester is granted.
- **ARB, both requesting:**
  - A wins unless `starve_cnt == STARVE_LIMIT`; then B wins.
  - `starve_cnt` increments on each cycle B is denied while `b_req=1`, saturating at `STARVE_LIMIT`.
  - `starve_cnt` clears on any B grant, and on any cycle `b_req=0`.
- **ARB → B_LOCKED:** taken when B is granted with `b_lock=1`. `lock_cnt` loads 1.
- **B_LOCKED:**
  - B is granted whenever `b_req=1`, and `lock_cnt` increments.
  - Exit to `ARB` when `b_lock=0`, or `b_req=0`, or `lock_cnt == MAX_LOCK` at a grant.
  - After a `MAX_LOCK` exit, A wins the next cycle if `a_req=1`, regardless of `b_lock`.
- **Mux:**
  - Granted port drives `mem_addr`, `mem_writedata`, `mem_size`.
  - `mem_we = gnt & we`; `mem_re = gnt & ~we`.
  - No grant: `mem_we = mem_re = 0`; address/data/size hold the A inputs.
- **Read return:**
  - A registered owner bit and pending flag record a granted read.
  - Next cycle, `mem_readdata` routes to that port's `rdata`, with its `rvalid` pulsed for one cycle.
  - The other port's `rvalid` is 0. `rdata` of a non-owner holds its last value.
  - Writes produce no `rvalid`.
- **Grants are combinational** from the requests and registered state. Requesters sample `gnt` at the clock edge; a granted request is consumed at that edge.
- `req` must not drop before `gnt`. Fields may change only after `gnt`.

## Timing
- **Grant latency:** 0 cycles; the `mem_*` controls are asserted in the grant cycle.
- **Read data latency:** 1 cycle after grant. Back-to-back reads from alternating ports are allowed every cycle; each `rvalid` tracks its own owner.
- **Reset (synchronous, takes effect at the edge):**
  - State goes to `ARB`; `starve_cnt`, `lock_cnt`, pending and owner clear.
  - `a_rvalid = b_rvalid = 0`; `a_rdata = b_rdata = 0`.
  - While `reset=1`: `a_gnt = b_gnt = mem_we = mem_re = 0`.
- **Reset mid-read:** the pending `rvalid` is cancelled and not delivered.
- **Simultaneous lock exit and A request:** `B_LOCKED` with `b_lock=0` and `b_req=1` grants B for this final beat; A arbitrates the next cycle.
- **Max width:** worst-case A stall is `MAX_LOCK + 1` cycles. Worst-case B wait is `STARVE_LIMIT + 1` cycles.

## Test plan
- **A-only traffic:** write 0xDEADBEEF to 0x100, then read 0x100 → `a_gnt=1` both cycles, `mem_we` then `mem_re`, `a_rvalid=1` with `a_rdata=0xDEADBEEF` one cycle after the read; `b_rvalid` stays 0.
- **Contention, STARVE_LIMIT=4:** `a_req` and `b_req` held high for 10 cycles, reads to distinct addresses → A granted cycles 0–3, B granted cycle 4, A granted cycles 5–8, B granted cycle 9.
- **Lock burst, MAX_LOCK=8:** B granted with `b_lock=1` held, `a_req=1` throughout → B granted 8 consecutive cycles, then A granted on the 9th even though `b_lock` is still 1.
- **Early lock release:** `b_lock` drops after the 3rd locked beat → B's 4th request is its final grant, then arbitration returns to A priority with `starve_cnt=0`.
- **Interleaved reads:** A reads 0x200 (data 0x11111111), B reads 0x204 (data 0x22222222) in consecutive cycles → `a_rvalid` then `b_rvalid` in consecutive cycles with the correct data, never both high.
- **Reset mid-operation:** assert `reset` the cycle after a B read grant → no `b_rvalid`; all grants, enables, and counters are 0; `a_req` alone after reset is granted immediately.
